mux_select_sequencer: RTL
=========================

# mux_select_sequencer

Round-robin select sequencer that sits directly upstream of the 4-to-1 behavioural multiplexer. It drives the mux's 2-bit `select`, holds each channel for a programmable dwell time, and samples the mux output back into a 4-bit frame register. Channels can be skipped through an enable mask. It signals completion with a one-cycle `frame_valid` pulse.

## Interface
- `DWELL`, default 4: cycles each enabled channel is held on `select`. Legal range is 1..256.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request one scan frame. Sampled only in IDLE.
- `enable_mask`  input  4  per-channel enable; bit i enables channel i. Latched when `start` is accepted.
- `m_in`  input  1  mux output (`m_out`) fed back for sampling.
- `select`  output  2  channel select to the mux.
- `busy`  output  1  high while a frame is in progress (HOLD or DONE).
- `frame`  output  4  sampled channel values; bit i holds channel i.
- `frame_valid`  output  1  one-cycle pulse when `frame` is complete.

## Operation
- **Reset values:** state = IDLE, `select` = 2'b00, `busy` = 0, `frame` = 4'b0000, `frame_valid` = 0, dwell counter = 0, latched mask = 0.
- **States:** IDLE, HOLD, DONE.
- **IDLE:**
  - `start` = 1 latches `enable_mask` and clears `frame` to 0.
  - If the mask is non-zero: `select` ← lowest enabled channel index, counter ← 0, go to HOLD.
  - If the mask is 0: go directly to DONE; `frame` stays 0.
  - `select` otherwise holds its last value.
- **HOLD:**
  - The counter increments each cycle.
  - When counter = DWELL-1, then on that edge:
    - `frame[select]` ← `m_in`;
    - counter ← 0;
    - `select` ← next higher enabled channel, if one exists (stay in HOLD); otherwise go to DONE and leave `select` unchanged.
  - No wrap-around: channels are scanned in ascending index order only, once per frame.
- **DONE:** `frame_valid` = 1 for exactly this one cycle, then unconditionally go to IDLE.
- **Disabled channels:** never selected; their `frame` bits read 0.
- **`start` outside IDLE:** ignored. Not queued.
- **Mask changes mid-frame:** `enable_mask` changes after acceptance have no effect on the current frame.
- **`reset` mid-frame:** aborts immediately to reset values on that edge. No `frame_valid` is issued.
- **`reset` and `start` in the same cycle:** `reset` wins.
- **Counter:** 8 bits wide, compared against DWELL-1. DWELL = 1 samples on every HOLD cycle.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `start` accepted at edge k:
  - `select` valid and `busy` = 1 from cycle k+1.
  - With n ≥ 1 enabled channels, samples are taken at edges k+DWELL, k+2·DWELL, …, k+n·DWELL.
  - Each sample sees `m_in` after the channel has been stable for DWELL cycles.
  - `frame_valid` = 1 and the final `frame` are visible in the cycle after edge k+n·DWELL.
  - Back in IDLE (`busy` = 0) after edge k+n·DWELL+1.
  - The earliest next accepted `start` is at edge k+n·DWELL+2.
- Mask = 0: `frame_valid` in the cycle after edge k; `busy` high for that single cycle.
- `frame` holds its value from `frame_valid` until the next accepted `start`.
- The mux is combinational, so `m_in` must settle within one cycle of a `select` change; DWELL ≥ 1 guarantees this.

## Test plan
- **Full scan:** DWELL=4, mask=4'b1111, mux inputs in_0..in_3 = 1,0,1,1, pulse `start` → `select` steps 0,1,2,3 for 4 cycles each; `frame_valid` 16 cycles after the start edge; `frame` = 4'b1101; `busy` drops 1 cycle later.
- **Sparse mask:** DWELL=2, mask=4'b1010, in_1=1, in_3=1 → `select` visits only 1 then 3; `frame` = 4'b1010; `frame_valid` 4 cycles after start.
- **Zero mask:** mask=4'b0000, `start` → `frame_valid` the next cycle; `frame` = 4'b0000; `select` unchanged.
- **Start while busy:** assert `start` repeatedly during HOLD and DONE → exactly one frame completes, and a second frame begins only after return to IDLE.
- **Reset mid-frame:** `reset` during the second channel's dwell → next cycle `select` = 0, `frame` = 0, `busy` = 0; no `frame_valid`. A subsequent `start` runs a clean frame.
- **DWELL=1 edge case:** mask=4'b0001, in_0 toggling → sample is taken on the first HOLD edge; `frame_valid` appears the cycle after the edge following the start edge; `frame[0]` equals `in_0` at that sampling edge.

Source files
------------

// File: rtl/mux_select_sequencer.sv
// Round-robin select sequencer for a 4-to-1 mux: dwells on each enabled channel,
// samples the fed-back mux output into a frame register, and pulses frame_valid.
//
// state | meaning
// IDLE  | waiting for start; select, frame hold their last values
// HOLD  | dwelling on channel `select`; sample m_in on the last dwell cycle
// DONE  | frame_valid pulse cycle; returns to IDLE unconditionally
module mux_select_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] enable_mask,
  input  logic       m_in,
  output logic [1:0] select,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] mask_q;
  logic [1:0] first_sel;
  logic [1:0] next_sel;
  logic       next_found;

  // Lowest enabled channel of the incoming mask, and the next higher enabled
  // channel above the current one in the latched mask (no wrap-around).
  always_comb begin
    first_sel  = 2'd0;
    next_sel   = select;
    next_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (enable_mask[i]) first_sel = 2'(i);
      if (mask_q[i] && (i > int'(select))) begin
        next_sel   = 2'(i);
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      select      <= 2'b00;
      busy        <= 1'b0;
      frame       <= 4'b0000;
      frame_valid <= 1'b0;
      cnt         <= 8'd0;
      mask_q      <= 4'b0000;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= enable_mask;
            frame  <= 4'b0000;
            busy   <= 1'b1;
            if (|enable_mask) begin
              select <= first_sel;
              cnt    <= 8'd0;
              state  <= HOLD;
            end else begin
              frame_valid <= 1'b1;
              state       <= DONE;
            end
          end
        end
        HOLD: begin
          if (cnt == CNT_LAST) begin
            frame[select] <= m_in;
            cnt           <= 8'd0;
            if (next_found) begin
              select <= next_sel;
            end else begin
              frame_valid <= 1'b1;
              state       <= DONE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
